// File: rtl/disp_hex_mux_gen_if.sv
// Display bus between the SoC display register block (master) and the
// seven-segment mux driver (slave).
interface disp_hex_mux_gen_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BRIGHT_W   = 4
);
  logic [4*NUM_DIGITS-1:0] hex_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic                    lz_suppress;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              sseg;
  logic                    frame_tick;

  modport master (
    output hex_in, dp_in, blank_in, blink_in, lz_suppress, brightness,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  hex_in, dp_in, blank_in, blink_in, lz_suppress, brightness,
    output an, sseg, frame_tick
  );
endinterface

// File: rtl/disp_hex_mux_gen.sv
// Time-multiplexed N-digit seven-segment hex driver with per-digit blank and
// blink, leading-zero suppression, PWM brightness, a one-clock dead time at
// each slot start, and a display snapshot taken once per frame.
module disp_hex_mux_gen #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned TICK_DIV   = 12500,
  parameter int unsigned BRIGHT_W   = 4,
  parameter int unsigned BLINK_W    = 9
) (
  input logic               clk,
  input logic               reset,
  disp_hex_mux_gen_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  // Scan state
  logic [PW-1:0]      r_presc;
  logic [IW-1:0]      r_idx;
  logic [BLINK_W-1:0] r_frame;

  // Frame snapshot; every display decision reads only these
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_blink;
  logic                    r_lz;
  logic [BRIGHT_W-1:0]     r_bright;

  // Registered pin drivers
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_sseg;
  logic                  r_frame_tick;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [NUM_DIGITS-1:0] w_supp;
  logic                  w_lead_seen;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic [6:0]            w_seg7;
  logic                  w_visible;
  logic [BRIGHT_W-1:0]   w_pwm;
  logic                  w_on;
  logic                  w_dead;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic [7:0]            w_sseg_next;

  assign w_slot_end  = (r_presc == PW'(TICK_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));

  // Advance prescaler, digit index and frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_frame <= '0;
    end else begin
      if (w_slot_end) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (w_frame_end) r_frame <= r_frame + 1'b1;
    end
  end

  // Capture all display controls together at the frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hex    <= '0;
      r_dp     <= '0;
      r_blank  <= '0;
      r_blink  <= '0;
      r_lz     <= 1'b0;
      r_bright <= '0;
    end else if (w_frame_end) begin
      r_hex    <= bus.hex_in;
      r_dp     <= bus.dp_in;
      r_blank  <= bus.blank_in;
      r_blink  <= bus.blink_in;
      r_lz     <= bus.lz_suppress;
      r_bright <= bus.brightness;
    end
  end

  // Scan from the most significant digit down; digit 0 is always shown
  always_comb begin
    w_supp      = '0;
    w_lead_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if ((r_hex[4*i +: 4] != 4'h0) || r_dp[i]) w_lead_seen = 1'b1;
      w_supp[i] = r_lz & ~w_lead_seen;
    end
  end

  assign w_nib = r_hex[{r_idx, 2'b00} +: 4];
  assign w_dp  = r_dp[r_idx];

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  always_comb begin
    w_seg7 = 7'h7F;
    case (w_nib)
      4'h0: w_seg7 = 7'b1000000;
      4'h1: w_seg7 = 7'b1111001;
      4'h2: w_seg7 = 7'b0100100;
      4'h3: w_seg7 = 7'b0110000;
      4'h4: w_seg7 = 7'b0011001;
      4'h5: w_seg7 = 7'b0010010;
      4'h6: w_seg7 = 7'b0000010;
      4'h7: w_seg7 = 7'b1111000;
      4'h8: w_seg7 = 7'b0000000;
      4'h9: w_seg7 = 7'b0010000;
      4'hA: w_seg7 = 7'b0001000;
      4'hB: w_seg7 = 7'b0000011;
      4'hC: w_seg7 = 7'b1000110;
      4'hD: w_seg7 = 7'b0100001;
      4'hE: w_seg7 = 7'b0000110;
      4'hF: w_seg7 = 7'b0001110;
      default: w_seg7 = 7'h7F;
    endcase
  end

  assign w_visible = ~r_blank[r_idx] & ~w_supp[r_idx] &
                     ~(r_blink[r_idx] & r_frame[BLINK_W-1]);
  assign w_pwm     = r_presc[BRIGHT_W-1:0];
  assign w_on      = (&r_bright) | (w_pwm < r_bright);
  // Anodes are forced off on the first clock of every slot to avoid ghosting
  assign w_dead    = (r_presc == '0);

  // Select the active anode for the current slot when lit
  always_comb begin
    w_an_next = '1;
    if (w_visible && w_on && !w_dead) w_an_next[r_idx] = 1'b0;
  end

  assign w_sseg_next = w_visible ? {~w_dp, w_seg7} : 8'hFF;

  // Register pin outputs; reset blanks the display immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an         <= '1;
      r_sseg       <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an_next;
      r_sseg       <= w_sseg_next;
      r_frame_tick <= w_frame_end;
    end
  end

  assign bus.an         = r_an;
  assign bus.sseg       = r_sseg;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_disp_hex_mux_gen.sv
// Self-checking bench for disp_hex_mux_gen: directed scenarios plus random
// input churn, compared every cycle against a time-indexed reference model.
module tb_disp_hex_mux_gen;

  localparam int N  = 8;
  localparam int TD = 32;
  localparam int BW = 4;
  localparam int KW = 2;
  localparam int FR = N * TD;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  disp_hex_mux_gen_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) u_if ();

  disp_hex_mux_gen #(
    .NUM_DIGITS(N),
    .TICK_DIV  (TD),
    .BRIGHT_W  (BW),
    .BLINK_W   (KW)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model: clocks since reset release and the snapshot it believes is held
  int              t;
  logic [4*N-1:0]  s_hex;
  logic [N-1:0]    s_dp, s_blank, s_blink;
  logic            s_lz;
  logic [BW-1:0]   s_bright;
  logic [6:0]      seg_tab [16];
  int              cnt [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; s_hex = '0; s_dp = '0; s_blank = '0; s_blink = '0; s_lz = 1'b0; s_bright = '0;
  endtask

  task automatic model_out(output logic [N-1:0] e_an, output logic [7:0] e_sseg,
                           output logic e_ft);
    int presc, slot, frame, lead;
    bit vis, on;
    logic [3:0] nib;
    presc = t % TD;
    slot  = (t / TD) % N;
    frame = t / FR;
    lead  = 0;
    for (int i = 0; i < N; i++) if (s_hex[i*4 +: 4] != 4'h0 || s_dp[i]) lead = i;
    nib = s_hex[slot*4 +: 4];
    vis = !s_blank[slot] && !(s_lz && slot > lead) &&
          !(s_blink[slot] && ((frame % (1 << KW)) >= (1 << (KW - 1))));
    on  = (s_bright == '1) || ((presc % (1 << BW)) < int'(s_bright));
    e_an = '1;
    if (vis && on && presc != 0) e_an[slot] = 1'b0;
    e_sseg = vis ? {~s_dp[slot], seg_tab[nib]} : 8'hFF;
    e_ft   = ((t % FR) == FR - 1);
  endtask

  task automatic step();
    logic [N-1:0] e_an;
    logic [7:0]   e_sseg;
    logic         e_ft;
    model_out(e_an, e_sseg, e_ft);
    @(posedge clk);
    if ((t % FR) == FR - 1) begin
      s_hex = u_if.hex_in; s_dp = u_if.dp_in; s_blank = u_if.blank_in;
      s_blink = u_if.blink_in; s_lz = u_if.lz_suppress; s_bright = u_if.brightness;
    end
    t++;
    @(negedge clk);
    check("an", 32'(u_if.an), 32'(e_an));
    check("sseg", 32'(u_if.sseg), 32'(e_sseg));
    check("frame_tick", 32'(u_if.frame_tick), 32'(e_ft));
  endtask

  // Stop once the outputs just sampled belong to (slot, presc)
  task automatic step_until(input int slot, input int presc);
    for (int k = 0; k <= FR; k++) begin
      step();
      if (((t - 1) / TD) % N == slot && (t - 1) % TD == presc) break;
    end
  endtask

  // Guarantee a frame boundary after the latest input change
  task automatic sync_frame();
    step();
    while (t % FR != 0) step();
  endtask

  task automatic count_frame();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < FR; k++) begin
      step();
      for (int i = 0; i < N; i++) if (!u_if.an[i]) cnt[i]++;
    end
  endtask

  task automatic rand_inputs();
    u_if.hex_in      = $urandom >> $urandom_range(0, 31);
    u_if.dp_in       = N'($urandom & $urandom & $urandom);
    u_if.blank_in    = N'($urandom & $urandom & $urandom);
    u_if.blink_in    = N'($urandom & $urandom);
    u_if.lz_suppress = 1'($urandom_range(0, 1));
    u_if.brightness  = BW'($urandom);
  endtask

  initial begin
    bit found;
    int total;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset = 1'b1;
    u_if.hex_in = '0; u_if.dp_in = '0; u_if.blank_in = '0; u_if.blink_in = '0;
    u_if.lz_suppress = 1'b0; u_if.brightness = '0;
    model_reset();
    #12;
    check("rst_an", 32'(u_if.an), 32'hFF);
    check("rst_sseg", 32'(u_if.sseg), 32'hFF);
    check("rst_ft", 32'(u_if.frame_tick), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    model_reset();

    // Basic scan
    u_if.brightness = 4'hF; u_if.hex_in = 32'h0123_4567;
    sync_frame();
    step_until(0, 4);
    check("t1_s0_an", 32'(u_if.an), 32'hFE);
    check("t1_s0_sseg", 32'(u_if.sseg), 32'hF8);
    step_until(7, 5);
    check("t1_s7_an", 32'(u_if.an), 32'h7F);
    check("t1_s7_sseg", 32'(u_if.sseg), 32'hC0);

    // Leading-zero suppression
    u_if.lz_suppress = 1'b1; u_if.hex_in = 32'h0000_00A0;
    sync_frame();
    step_until(0, 5);
    check("t2_d0_sseg", 32'(u_if.sseg), 32'hC0);
    step_until(1, 5);
    check("t2_d1_sseg", 32'(u_if.sseg), 32'h88);
    check("t2_d1_an", 32'(u_if.an), 32'hFD);
    step_until(4, 5);
    check("t2_d4_an", 32'(u_if.an), 32'hFF);
    u_if.dp_in = 8'h20;
    sync_frame();
    step_until(3, 5);
    check("t2dp_d3_sseg", 32'(u_if.sseg), 32'hC0);
    step_until(5, 5);
    check("t2dp_d5_sseg", 32'(u_if.sseg), 32'h40);
    check("t2dp_d5_an", 32'(u_if.an), 32'hDF);

    // Brightness
    u_if.lz_suppress = 1'b0; u_if.dp_in = '0; u_if.brightness = 4'h0;
    sync_frame();
    count_frame();
    total = 0;
    for (int i = 0; i < N; i++) total += cnt[i];
    check("t3_b0_lit", 32'(total), 32'd0);
    u_if.brightness = 4'h8;
    sync_frame();
    count_frame();
    for (int i = 0; i < N; i++) check($sformatf("t3_b8_slot%0d", i), 32'(cnt[i]), 32'd15);

    // Frame coherence: a change in slot 3 must not reach slots 4..7 this frame
    u_if.brightness = 4'hF; u_if.hex_in = 32'h1111_1111;
    sync_frame();
    step_until(3, 10);
    u_if.hex_in = $urandom | 32'h2000_0000;
    step_until(7, 5);
    check("t4_s7_old", 32'(u_if.sseg), 32'hF9);
    sync_frame();
    count_frame();

    // Blink over a few frames
    u_if.hex_in = '0; u_if.blink_in = 8'h01;
    for (int f = 0; f < 5; f++) sync_frame();

    // Asynchronous reset mid-slot 5
    u_if.blink_in = '0; u_if.hex_in = 32'h1234_5670;
    sync_frame();
    step_until(5, 10);
    #2 reset = 1'b1;
    #1;
    check("t6_an", 32'(u_if.an), 32'hFF);
    check("t6_sseg", 32'(u_if.sseg), 32'hFF);
    check("t6_ft", 32'(u_if.frame_tick), 32'h0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    model_reset();
    found = 1'b0;
    for (int k = 0; k < 3 * FR && !found; k++) begin
      step();
      if (u_if.an != '1) begin
        found = 1'b1;
        check("t6_first_an", 32'(u_if.an), 32'hFE);
        check("t6_first_sseg", 32'(u_if.sseg), 32'hC0);
      end
    end
    check("t6_lit_found", 32'(found), 32'd1);

    // Random churn, including mid-frame changes
    for (int k = 0; k < 24 * FR; k++) begin
      if ($urandom_range(0, 149) == 0) rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
